// File: rtl/str_transform_engine.sv
// str_transform_engine: buffers one string per transaction and replays it as pass, upper, lower or reversed
// Ports: in_valid/in_ready/in_data/in_last/in_mode is the character input stream (mode taken from the first char);
//        out_valid/out_ready/out_data/out_last/out_len/out_err is the transformed output stream.
// Optional: define STRPROC_STATS_EN to add saturating str_count/ovf_count outputs.
module str_transform_engine #(
  parameter int CHAR_W  = 8,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_data,
  input  logic              in_last,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_data,
  output logic              out_last,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_err
`ifdef STRPROC_STATS_EN
  ,
  output logic [15:0]       str_count,
  output logic [15:0]       ovf_count
`endif
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, new_len;
  logic [1:0] mode_q, mode_d, eff_mode;
  logic ovf_q, ovf_d, in_hs, out_hs, wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [MAX_LEN-1:0][CHAR_W-1:0] mem_q;
  function automatic logic [CHAR_W-1:0] xf(input logic [CHAR_W-1:0] c, input logic [1:0] m);
    logic [7:0] lo;
    lo = c[7:0];
    xf = c;
    xf[7:0] = (m == 2'd1 && lo >= 8'h61 && lo <= 8'h7a) ? lo - 8'h20 :
              (m == 2'd2 && lo >= 8'h41 && lo <= 8'h5a) ? lo + 8'h20 : lo;
  endfunction
  assign in_ready  = state_q != EMIT;
  assign out_valid = state_q == EMIT;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  // the mode register is not loaded yet while the first char is in flight
  assign eff_mode  = state_q == IDLE ? in_mode : mode_q;
  assign new_len   = state_q == IDLE ? LEN_W'(1) : (len_q < MAX_L ? len_q + 1'b1 : len_q);
  assign wr_en     = in_hs & (state_q == IDLE | len_q < MAX_L);
  assign wr_idx    = state_q == IDLE ? '0 : len_q[IDX_W-1:0];
  assign out_last  = out_valid & (mode_q == 2'd3 ? idx_q == '0 : idx_q == len_q - 1'b1);
  assign out_data  = out_valid ? xf(mem_q[idx_q[IDX_W-1:0]], mode_q) : '0;
  assign out_len   = out_valid ? len_q : '0;
  assign out_err   = out_valid & ovf_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    if (in_hs) begin
      len_d   = new_len;
      mode_d  = eff_mode;
      ovf_d   = state_q == IDLE ? 1'b0 : ovf_q | (len_q == MAX_L);
      state_d = in_last ? EMIT : LOAD;
      idx_d   = eff_mode == 2'd3 ? new_len - 1'b1 : '0;
    end else if (out_hs) begin
      state_d = out_last ? IDLE : EMIT;
      idx_d   = mode_q == 2'd3 ? idx_q - 1'b1 : idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= in_data;
  end
`ifdef STRPROC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_count <= '0;
      ovf_count <= '0;
    end else if (out_hs && out_last) begin
      str_count <= str_count + {15'd0, str_count != 16'hffff};
      ovf_count <= ovf_count + {15'd0, out_err && ovf_count != 16'hffff};
    end
  end
`endif
endmodule

// File: tb/tb_str_transform_engine.sv
// tb_str_transform_engine: string-level model and per-cycle compare against two engine instances (MAX_LEN 32 and 4)
module tb_str_transform_engine;
  typedef struct {
    logic [7:0] d;
    bit         last;
    int         len;
    bit         err;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_last, out_ready, sel;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic r32, v32, l32, e32, r4, v4, l4, e4;
  logic [7:0] d32, d4;
  logic [5:0] n32;
  logic [2:0] n4;
  logic in_ready_s, out_valid_s, out_last_s, out_err_s;
  logic [7:0] out_data_s;
  logic [5:0] out_len_s;
`ifdef STRPROC_STATS_EN
  logic [15:0] sc32, oc32, sc4, oc4;
`endif
  int checks = 0, errors = 0, ycnt = 0, stall_left = 0;
  int str_exp[2], ovf_exp[2];
  bit rnd_rdy = 0, rdy_off = 0;
  logic [7:0] stall_ch = 8'h00;
  beat_t q[$];

  always #5 clk = ~clk;

  str_transform_engine dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & !sel), .in_ready(r32), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .out_valid(v32), .out_ready(out_ready), .out_data(d32),
    .out_last(l32), .out_len(n32), .out_err(e32)
`ifdef STRPROC_STATS_EN
    , .str_count(sc32), .ovf_count(oc32)
`endif
  );
  str_transform_engine #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(r4), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode), .out_valid(v4), .out_ready(out_ready), .out_data(d4),
    .out_last(l4), .out_len(n4), .out_err(e4)
`ifdef STRPROC_STATS_EN
    , .str_count(sc4), .ovf_count(oc4)
`endif
  );

  assign in_ready_s  = sel ? r4 : r32;
  assign out_valid_s = sel ? v4 : v32;
  assign out_data_s  = sel ? d4 : d32;
  assign out_last_s  = sel ? l4 : l32;
  assign out_err_s   = sel ? e4 : e32;
  assign out_len_s   = sel ? {3'b000, n4} : n32;

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  task automatic chks(string n, string got, string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got \"%s\" expected \"%s\"", n, got, exp);
    end
  endtask

  function automatic int ml();
    return sel ? 4 : 32;
  endfunction

  // expected output text: truncate to the buffer size, optionally reverse, then case-map
  function automatic string xform(string s, int mode, int lim);
    int n = s.len() < lim ? s.len() : lim;
    string r = s.substr(0, n - 1);
    for (int i = 0; i < n; i++) begin
      logic [7:0] c = s[mode == 3 ? n - 1 - i : i];
      if (mode == 1 && c >= "a" && c <= "z") c = c - 8'd32;
      if (mode == 2 && c >= "A" && c <= "Z") c = c + 8'd32;
      r.putc(i, c);
    end
    return r;
  endfunction

  function automatic string rnd_str(int n);
    logic [7:0] bnd [8] = '{8'h40, 8'h41, 8'h5a, 8'h5b, 8'h60, 8'h61, 8'h7a, 8'h7b};
    string s = "0123456789012345678901234567890123456789";
    s = s.substr(0, n - 1);
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(0, 3);
      logic [7:0] c;
      if (k == 0) c = 8'($urandom_range(8'h61, 8'h7a));
      else if (k == 1) c = 8'($urandom_range(8'h41, 8'h5a));
      else if (k == 2) c = bnd[$urandom_range(0, 7)];
      else c = 8'($urandom_range(1, 255));
      s.putc(i, c);
    end
    return s;
  endfunction

  task automatic expect_str(string s, int mode);
    string t = xform(s, mode, ml());
    for (int i = 0; i < t.len(); i++) begin
      beat_t b;
      b.d = t[i];
      b.last = i == t.len() - 1;
      b.len = t.len();
      b.err = s.len() > ml();
      q.push_back(b);
    end
  endtask

  task automatic send(string s, int mode, int n, bit fin, bit gaps);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      bit hs = 0;
      in_valid = 1'b1;
      in_data = s[i];
      in_last = fin && i == n - 1;
      in_mode = i == 0 ? 2'(mode) : 2'($urandom);
      while (!hs && w < 3000) begin
        @(negedge clk);
        hs = in_ready_s;
        @(posedge clk); #1;
        w++;
      end
      if (!hs) begin
        chk("in_handshake_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = 8'($urandom);
      in_mode = 2'($urandom);
      if (fin && i == n - 1) expect_str(s.substr(0, n - 1), mode);
      else if (gaps && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (q.size() != 0 || out_valid_s); i++) @(negedge clk);
    chk("drain_pending_beats", q.size(), 0);
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_in_ready32"}, int'(r32), 1);
    chk({tag, "_out_valid32"}, int'(v32), 0);
    chk({tag, "_out_data32"}, int'(d32), 0);
    chk({tag, "_out_last32"}, int'(l32), 0);
    chk({tag, "_out_len32"}, int'(n32), 0);
    chk({tag, "_out_err32"}, int'(e32), 0);
    chk({tag, "_in_ready4"}, int'(r4), 1);
    chk({tag, "_out_valid4"}, int'(v4), 0);
    chk({tag, "_out_data4"}, int'(d4), 0);
    chk({tag, "_out_last4"}, int'(l4), 0);
    chk({tag, "_out_len4"}, int'(n4), 0);
    chk({tag, "_out_err4"}, int'(e4), 0);
`ifdef STRPROC_STATS_EN
    chk({tag, "_str_count"}, int'(sc32) + int'(sc4), 0);
    chk({tag, "_ovf_count"}, int'(oc32) + int'(oc4), 0);
`endif
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    str_exp = '{0, 0};
    ovf_exp = '{0, 0};
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && out_valid_s && out_data_s == stall_ch) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = rdy_off ? 1'b0 : (rnd_rdy ? $urandom_range(0, 3) != 0 : 1'b1);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid_s), int'(q.size() != 0));
      chk("in_ready", int'(in_ready_s), int'(!out_valid_s));
      chk("idle_instance_valid", int'(sel ? v32 : v4), 0);
`ifdef STRPROC_STATS_EN
      chk("str_count", int'(sel ? sc4 : sc32), str_exp[sel]);
      chk("ovf_count", int'(sel ? oc4 : oc32), ovf_exp[sel]);
`endif
      if (out_valid_s && out_data_s == "y") ycnt++;
      if (out_valid_s && q.size() != 0) begin
        chk("out_data", int'(out_data_s), int'(q[0].d));
        chk("out_last", int'(out_last_s), int'(q[0].last));
        chk("out_len", int'(out_len_s), q[0].len);
        chk("out_err", int'(out_err_s), int'(q[0].err));
        if (out_ready) begin
          if (q[0].last) begin
            str_exp[sel]++;
            if (q[0].err) ovf_exp[sel]++;
          end
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    in_mode = 2'd0;
    sel = 1'b0;
    out_ready = 1'b1;
    str_exp = '{0, 0};
    ovf_exp = '{0, 0};
    chks("model_hello", xform("hello", 1, 32), "HELLO");
    chks("model_abc_rev", xform("abc", 3, 32), "cba");
    chks("model_ovf", xform("abcdef", 0, 4), "abcd");
    chks("model_lower", xform("Q", 2, 32), "q");
    chks("model_bounds_up", xform("@AZ[`az{", 1, 32), "@AZ[`AZ{");
    chks("model_bounds_dn", xform("@AZ[`az{", 2, 32), "@az[`az{");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send("hello", 1, 5, 1, 0);
    drain();
    send("abc", 3, 3, 1, 0);
    drain();
    send("Q", 2, 1, 1, 0);
    drain();
    ycnt = 0;
    stall_ch = "y";
    stall_left = 3;
    send("xyz", 0, 3, 1, 0);
    drain();
    chk("y_held_cycles", ycnt, 4);
    sel = 1'b1;
    send("abcdef", 0, 6, 1, 0);
    drain();
`ifdef STRPROC_STATS_EN
    chk("ovf_str_count", int'(sc4), 1);
    chk("ovf_ovf_count", int'(oc4), 1);
`endif
    send("test", 0, 2, 0, 0);
    reset_pulse();
    send("ok", 1, 2, 1, 0);
    drain();
    rdy_off = 1'b1;
    send("abcd", 3, 4, 1, 0);
    repeat (2) @(negedge clk);
    reset_pulse();
    rdy_off = 1'b0;
    repeat (4) @(negedge clk);
    rnd_rdy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 40; k++) begin
        int n = s == 1 ? $urandom_range(1, 7) : $urandom_range(1, 40);
        send(rnd_str(n), $urandom_range(0, 3), n, 1, 1);
      end
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/str_transform_engine.md
Name: str_transform_engine

Overview:
- Parametrised character-stream engine for the string-processing datapath.
- Accepts one string per transaction on a valid/ready input stream, with `in_last` marking the final character.
- Buffers up to MAX_LEN characters, then emits the string on a valid/ready output stream with a per-string transform: pass, uppercase, lowercase or reverse.
- Successor to the fixed small-string path: width, length and mode are now configurable, and it adds overflow detection and backpressure.

Parameters:
- CHAR_W, 8, character width in bits (≥8). Case transforms act on bits [7:0]; upper bits pass through unchanged.
- MAX_LEN, 32, maximum stored characters per string (≥2).
- LEN_W, $clog2(MAX_LEN+1), length field width. Derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input character valid.
- in_ready  out  1  engine can accept a character.
- in_data  in  CHAR_W  input character.
- in_last  in  1  final character of the string.
- in_mode  in  2  transform: 0 pass, 1 upper, 2 lower, 3 reverse. Sampled with the first character only.
- out_valid  out  1  output character valid.
- out_ready  in  1  downstream accepts.
- out_data  out  CHAR_W  transformed character.
- out_last  out  1  final output character.
- out_len  out  LEN_W  stored length of the string being emitted. Constant for all beats.
- out_err  out  1  string overflowed. Valid on every beat of that string.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, out_len=0, out_err=0. State=IDLE, length counter=0, overflow flag=0.
- A handshake is valid&ready high at a rising clk edge.
- FSM states: IDLE, LOAD, EMIT.
- IDLE:
  - in_ready=1.
  - On handshake: store char at buf[0], len=1, latch in_mode, clear overflow.
  - If in_last, go to EMIT; otherwise go to LOAD.
- LOAD:
  - in_ready=1.
  - On handshake with len<MAX_LEN: store at buf[len], len++.
  - On handshake with len==MAX_LEN: drop the char, set overflow (sticky for this string).
  - in_last handshake (stored or dropped) goes to EMIT.
  - in_mode changes after the first char are ignored.
- EMIT:
  - in_ready=0.
  - out_valid=1 starting the cycle after the in_last handshake (1-cycle latency).
  - Index runs 0..len-1 for modes 0–2, and len-1..0 for mode 3.
  - Index advances only on an out handshake.
  - out_last=1 on the final index.
  - After the out_last handshake: out_valid=0 and in_ready=1 on the next cycle; go to IDLE.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_last, out_len and out_err are held stable.
- Transform, applied to bits [7:0] only:
  - Mode 1: 0x61–0x7A minus 0x20.
  - Mode 2: 0x41–0x5A plus 0x20.
  - All other codes pass unchanged.
  - Mode 3 reverses order only, with no case change.
- No overlap: no input is accepted while EMIT is active.
- Reset asserted mid-LOAD or mid-EMIT: the partial or pending string is discarded, all outputs go to reset values immediately, and there is no stray out_valid after release.
- Length wrap cannot occur: len saturates at MAX_LEN.
- X on in_data without in_valid must not affect state.

Optional Feature:
- Macro STRPROC_STATS_EN.
- When defined:
  - Adds outputs str_count [15:0] and ovf_count [15:0], both reset to 0.
  - str_count increments on each out_last handshake.
  - ovf_count increments on each out_last handshake whose out_err=1.
  - Both counters saturate at 0xFFFF.
- When undefined: both ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- "hello", mode 1 → "HELLO"; out_len=5, out_last on 'O', out_err=0; first out_valid 1 cycle after the 'o' handshake.
- "abc", mode 3 → "cba"; out_last on 'a'; in_ready=0 during emit and 1 the cycle after the last handshake.
- MAX_LEN=4, "abcdef" with in_last on 'f', mode 0 → "abcd"; out_len=4, out_err=1 on all beats; with STRPROC_STATS_EN, ovf_count=1 and str_count=1.
- Single 'Q' with in_last, mode 2; mode changed to 1 on the next cycle → 'q', out_last=1, out_len=1.
- "xyz", mode 0, out_ready held low 3 cycles on 'y' → 'y' held stable with out_valid=1 for 4 cycles; then 'z'; in_ready stays 0 throughout.
- rst_n pulsed low after 2 chars of "test" in LOAD → all outputs return to reset values; the next string "ok", mode 1, yields "OK", out_len=2, out_err=0.
